// File: rtl/bram_dump_reader.sv
// Walks an inclusive (wrapping) RAM address range and streams each word out MSB-first as bytes.
// Latency: first byte valid 2 edges after start; each word costs BYTES transfer cycles + 1 fetch cycle.
// Backpressure: o_tx_data/o_tx_valid hold while i_tx_ready is low, for any stall length.
module bram_dump_reader #(
    parameter int ADDRESS_BITS = 8,
    parameter int DATA_BITS    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_start,
    input  logic [ADDRESS_BITS-1:0] i_first_addr,
    input  logic [ADDRESS_BITS-1:0] i_last_addr,
    output logic [ADDRESS_BITS-1:0] o_mem_address,
    input  logic [DATA_BITS-1:0]    i_mem_data,
    output logic [7:0]              o_tx_data,
    output logic                    o_tx_valid,
    input  logic                    i_tx_ready,
    output logic                    o_busy,
    output logic                    o_done
);

    localparam int BYTES = DATA_BITS / 8;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND
    } state_t;

    state_t                  state;
    logic [ADDRESS_BITS-1:0] last_addr;
    logic [DATA_BITS-1:0]    word_q;
    logic [CNT_W-1:0]        byte_cnt;
    logic [DATA_BITS-1:0]    word_shift;

    // The next byte to present is always the top byte of the word shifted left by one byte.
    always_comb begin
        word_shift = word_q << 8;
    end

    // Dump sequencer: latch range, fetch a word, serialize it, advance or finish.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            last_addr     <= '0;
            word_q        <= '0;
            byte_cnt      <= '0;
            o_mem_address <= '0;
            o_tx_data     <= '0;
            o_tx_valid    <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        last_addr     <= i_last_addr;
                        o_mem_address <= i_first_addr;
                        o_busy        <= 1'b1;
                        state         <= FETCH;
                    end
                end
                FETCH: begin
                    // Address was stable across the falling edge, so the RAM word is valid here.
                    word_q     <= i_mem_data;
                    o_tx_data  <= i_mem_data[DATA_BITS-1 -: 8];
                    o_tx_valid <= 1'b1;
                    byte_cnt   <= '0;
                    state      <= SEND;
                end
                SEND: begin
                    // o_tx_valid is always high in SEND, so ready alone marks a transfer.
                    if (i_tx_ready) begin
                        if (byte_cnt != LAST_CNT) begin
                            word_q    <= word_shift;
                            o_tx_data <= word_shift[DATA_BITS-1 -: 8];
                            byte_cnt  <= byte_cnt + CNT_W'(1);
                        end else begin
                            o_tx_valid <= 1'b0;
                            if (o_mem_address == last_addr) begin
                                o_busy <= 1'b0;
                                o_done <= 1'b1;
                                state  <= IDLE;
                            end else begin
                                o_mem_address <= o_mem_address + ADDRESS_BITS'(1);
                                state         <= FETCH;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_dump_reader.sv
module tb_bram_dump_reader;

    localparam int AB = 8;
    localparam int DB = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start;
    logic [AB-1:0] i_first_addr;
    logic [AB-1:0] i_last_addr;
    logic [AB-1:0] o_mem_address;
    logic [DB-1:0] i_mem_data;
    logic [7:0]    o_tx_data;
    logic          o_tx_valid;
    logic          i_tx_ready;
    logic          o_busy;
    logic          o_done;

    bram_dump_reader #(.ADDRESS_BITS(AB), .DATA_BITS(DB)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_first_addr (i_first_addr),
        .i_last_addr  (i_last_addr),
        .o_mem_address(o_mem_address),
        .i_mem_data   (i_mem_data),
        .o_tx_data    (o_tx_data),
        .o_tx_valid   (o_tx_valid),
        .i_tx_ready   (i_tx_ready),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    always #5 clk = ~clk;

    // Synchronous RAM model: read data follows the address on the falling edge.
    logic [DB-1:0] ram [256];
    always @(negedge clk) i_mem_data = ram[o_mem_address];

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    typedef struct {
        logic [7:0] f;
        logic [7:0] l;
        int stall_pct;
        int stall_idx;
        int stall_len;
        int mid_start;
        int exp_words;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Number of words in an inclusive wrapping range.
    function automatic int word_count(input logic [7:0] f, input logic [7:0] l);
        logic [7:0] d;
        d = l - f;
        return int'(d) + 1;
    endfunction

    // Expected byte stream: words in address order modulo 256, each MSB first.
    task automatic build_expected(input logic [7:0] f, input logic [7:0] l);
        logic [7:0]  a;
        logic [31:0] w;
        exp_q.delete();
        for (int k = 0; k < word_count(f, l); k++) begin
            a = f + 8'(k);
            w = ram[a];
            for (int b = 3; b >= 0; b--) exp_q.push_back(w[8*b +: 8]);
        end
    endtask

    task automatic run_dump(input int id, input logic [7:0] f, input logic [7:0] l,
                            input int stall_pct, input int stall_idx, input int stall_len,
                            input int mid_start, input int exp_words);
        int n_words, busy_cnt, done_cnt, done_at, stall_cnt, stab_err, stalled, byte_err;
        logic saw9, prev_stall, rdy, finished;
        logic [7:0] prev_data;
        n_words = word_count(f, l);
        busy_cnt = 0; done_cnt = 0; done_at = 0; stall_cnt = 0; stab_err = 0;
        stalled = 0; byte_err = 0; saw9 = 1'b0; prev_stall = 1'b0; finished = 1'b0;
        prev_data = 8'h00;
        build_expected(f, l);
        got_q.delete();
        @(negedge clk);
        i_first_addr = f;
        i_last_addr  = l;
        i_start      = 1'b1;
        i_tx_ready   = 1'b1;
        for (int n = 1; n <= 20000; n++) begin
            @(negedge clk);
            if (n == 1) begin
                i_start      = 1'b0;
                i_first_addr = 8'($urandom);
                i_last_addr  = 8'($urandom);
            end
            if (mid_start > 0 && n == mid_start) begin
                i_start      = 1'b1;
                i_first_addr = 8'd9;
                i_last_addr  = 8'd9;
            end
            if (mid_start > 0 && n == mid_start + 1) i_start = 1'b0;
            if (o_mem_address == 8'd9) saw9 = 1'b1;
            if (prev_stall && (o_tx_valid !== 1'b1 || o_tx_data !== prev_data)) stab_err++;
            if (o_busy) busy_cnt++;
            if (o_done) begin
                done_cnt++;
                if (done_at == 0) done_at = n;
            end
            rdy = 1'b1;
            if (stall_pct > 0 && $urandom_range(99) < stall_pct) rdy = 1'b0;
            if (stall_idx >= 0 && o_tx_valid && got_q.size() == stall_idx && stalled < stall_len) begin
                rdy = 1'b0;
                stalled++;
            end
            i_tx_ready = rdy;
            prev_stall = o_tx_valid && !rdy;
            prev_data  = o_tx_data;
            if (prev_stall) stall_cnt++;
            if (o_tx_valid && rdy) got_q.push_back(o_tx_data);
            if (done_at > 0 && n >= done_at + 2) begin
                finished = 1'b1;
                break;
            end
        end
        i_tx_ready = 1'b1;
        check($sformatf("dump%0d_finished", id), 64'(finished), 64'd1);
        check($sformatf("dump%0d_byte_count", id), 64'(got_q.size()), 64'(exp_words * 4));
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) byte_err++;
        check($sformatf("dump%0d_byte_mismatches", id), 64'(byte_err), 64'd0);
        check($sformatf("dump%0d_done_pulses", id), 64'(done_cnt), 64'd1);
        check($sformatf("dump%0d_busy_cycles", id), 64'(busy_cnt), 64'(n_words * 5 + stall_cnt));
        if (stall_cnt == 0)
            check($sformatf("dump%0d_done_cycle", id), 64'(done_at), 64'(n_words * 5 + 1));
        if (stall_cnt > 0)
            check($sformatf("dump%0d_stall_stability", id), 64'(stab_err), 64'd0);
        if (mid_start > 0)
            check($sformatf("dump%0d_addr9_seen", id), 64'(saw9), 64'd0);
        check($sformatf("dump%0d_busy_end", id), 64'(o_busy), 64'd0);
    endtask

    initial begin
        int found, nd;
        logic [7:0] rf, rl;

        for (int i = 0; i < 256; i++) ram[i] = $urandom;
        ram[0] = 32'h0000_0001;
        ram[1] = 32'h0000_0002;
        ram[2] = 32'h0000_0003;
        ram[5] = 32'hA1B2_C3D4;
        ram[9] = 32'h9999_9999;

        vecs[0] = '{f: 8'd5,   l: 8'd5,   stall_pct: 0, stall_idx: -1, stall_len: 0, mid_start: 0, exp_words: 1};
        vecs[1] = '{f: 8'd0,   l: 8'd2,   stall_pct: 0, stall_idx: -1, stall_len: 0, mid_start: 0, exp_words: 3};
        vecs[2] = '{f: 8'd5,   l: 8'd5,   stall_pct: 0, stall_idx: 1,  stall_len: 3, mid_start: 0, exp_words: 1};
        vecs[3] = '{f: 8'hFE,  l: 8'h01,  stall_pct: 0, stall_idx: -1, stall_len: 0, mid_start: 0, exp_words: 4};
        vecs[4] = '{f: 8'd0,   l: 8'd1,   stall_pct: 0, stall_idx: -1, stall_len: 0, mid_start: 3, exp_words: 2};
        vecs[5] = '{f: 8'd10,  l: 8'd9,   stall_pct: 0, stall_idx: -1, stall_len: 0, mid_start: 0, exp_words: 256};

        rst = 1'b0; i_start = 1'b0; i_first_addr = '0; i_last_addr = '0; i_tx_ready = 1'b1;
        #12;
        check("reset_addr",  64'(o_mem_address), 64'd0);
        check("reset_data",  64'(o_tx_data), 64'd0);
        check("reset_valid", 64'(o_tx_valid), 64'd0);
        check("reset_busy",  64'(o_busy), 64'd0);
        check("reset_done",  64'(o_done), 64'd0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 6; v++)
            run_dump(v, vecs[v].f, vecs[v].l, vecs[v].stall_pct, vecs[v].stall_idx,
                     vecs[v].stall_len, vecs[v].mid_start, vecs[v].exp_words);

        // Reset while the third byte is on the bus.
        @(negedge clk);
        i_first_addr = 8'd5; i_last_addr = 8'd5; i_start = 1'b1; i_tx_ready = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            i_start = 1'b0;
        end
        check("rstmid_third_byte", 64'(o_tx_data), 64'(ram[5][15:8]));
        #1 rst = 1'b0;
        #1;
        check("rstmid_valid", 64'(o_tx_valid), 64'd0);
        check("rstmid_busy",  64'(o_busy), 64'd0);
        check("rstmid_addr",  64'(o_mem_address), 64'd0);
        check("rstmid_data",  64'(o_tx_data), 64'd0);
        @(negedge clk); rst = 1'b1;
        nd = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (o_done || o_busy) nd++;
        end
        check("rstmid_quiet_after", 64'(nd), 64'd0);
        run_dump(10, 8'd5, 8'd5, 0, -1, 0, 0, 1);

        // Start held high through done: next dump begins on the edge after done rises.
        @(negedge clk);
        i_first_addr = 8'd3; i_last_addr = 8'd3; i_start = 1'b1; i_tx_ready = 1'b1;
        found = 0;
        for (int n = 1; n <= 50; n++) begin
            @(negedge clk);
            if (o_done) begin
                found = n;
                break;
            end
        end
        check("hold_done_cycle", 64'(found), 64'd6);
        i_first_addr = 8'd7; i_last_addr = 8'd7;
        @(negedge clk);
        check("hold_restart_busy", 64'(o_busy), 64'd1);
        check("hold_restart_addr", 64'(o_mem_address), 64'd7);
        i_start = 1'b0;
        #1 rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);

        // Randomized short dumps with random backpressure.
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 256; i++) ram[i] = $urandom;
            rf = 8'($urandom_range(255));
            rl = rf + 8'($urandom_range(7));
            run_dump(100 + r, rf, rl, int'($urandom_range(50)), -1, 0, 0, word_count(rf, rl));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
